// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and baud divider helpers.
// Used by both the transmitter and the fabric receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  function automatic int uart_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  function automatic int uart_half_div(
    input int clk_hz,
    input int baud
  );
    return uart_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-cell timer: counts 0..DIV-1 and pulses cell_end on the last clock.
// A synchronous clear parks the count at zero between frames.
module uart_baud_cnt #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic cell_end
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cell_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign cell_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_dbuf.sv
// 8-N-1 UART transmitter with a one-byte holding register ahead of the
// shifter, so back-to-back frames go out with no idle gap.
module uart_tx_dbuf
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 2_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       txo,
  output logic       tx_busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_tx_dbuf: need DIV >= 2 and STOP_BITS in {1,2}");
  end

  uart_state_t state, state_nx;
  logic       hold_full;
  logic [7:0] hold;
  logic [7:0] shreg, shreg_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [2:0] idx_inc;
  logic       stop_cnt, stop_cnt_nx;
  logic       txo_nx;
  logic       load;
  logic       cell_end;

  uart_baud_cnt #(
    .DIV(DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_IDLE),
    .cell_end(cell_end)
  );

  assign tx_rdy  = !hold_full;
  assign tx_busy = (state != S_IDLE);
  assign idx_inc = bit_idx + 3'd1;

  // load only fires while hold_full is set, so it never meets an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else if (tx_vld && tx_rdy) begin
      hold_full <= 1'b1;
      hold      <= tx_byte;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      txo      <= 1'b1;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_idx  <= bit_idx_nx;
      stop_cnt <= stop_cnt_nx;
      txo      <= txo_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_idx_nx  = bit_idx;
    stop_cnt_nx = stop_cnt;
    txo_nx      = txo;
    load        = 1'b0;
    unique case (state)
      S_IDLE: begin
        txo_nx = 1'b1;
        load   = hold_full;
      end
      S_START: begin
        if (cell_end) begin
          txo_nx     = shreg[0];
          bit_idx_nx = '0;
          state_nx   = S_DATA;
        end
      end
      S_DATA: begin
        if (cell_end) begin
          if (bit_idx == 3'd7) begin
            txo_nx      = 1'b1;
            stop_cnt_nx = 1'b0;
            state_nx    = S_STOP;
          end else begin
            txo_nx     = shreg[idx_inc];
            bit_idx_nx = idx_inc;
          end
        end
      end
      S_STOP: begin
        if (cell_end) begin
          if (stop_cnt == STOP_LAST) begin
            load     = hold_full;
            state_nx = S_IDLE;
          end else begin
            stop_cnt_nx = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // chaining straight from the last stop clock avoids an idle cell
    if (load) begin
      shreg_nx = hold;
      txo_nx   = 1'b0;
      state_nx = S_START;
    end
  end

endmodule

// File: tb/tb_uart_tx_dbuf.sv
// Bench for uart_tx_dbuf: frame waveform table, back-to-back, stop bits,
// mid-frame reset, and a serial decoder scoreboard over random traffic.
module tb_uart_tx_dbuf;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_vld  [3];
  logic [7:0] tx_byte [3];
  logic       tx_rdy  [3];
  logic       txo     [3];
  logic       tx_busy [3];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_viol = 0;
  int fr_err = 0;
  int acc_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] bq[$];
  bit exp_q[$];
  vec_t tbl[5];
  bit ok_g;
  int bad;
  int tmo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_dbuf u_a (
    .clk(clk), .rst_n(rst_n),
    .tx_byte(tx_byte[0]), .tx_vld(tx_vld[0]), .tx_rdy(tx_rdy[0]),
    .txo(txo[0]), .tx_busy(tx_busy[0])
  );

  uart_tx_dbuf #(.STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .tx_byte(tx_byte[1]), .tx_vld(tx_vld[1]), .tx_rdy(tx_rdy[1]),
    .txo(txo[1]), .tx_busy(tx_busy[1])
  );

  uart_tx_dbuf #(.CLK_HZ(6), .BAUD(2), .STOP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .tx_byte(tx_byte[2]), .tx_vld(tx_vld[2]), .tx_rdy(tx_rdy[2]),
    .txo(txo[2]), .tx_busy(tx_busy[2])
  );

  function automatic int div_of(input int u);
    return (u == 2) ? 3 : 50;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input int stops);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_start(input int u, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (txo[u] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Compares txo/tx_busy cycle by cycle against exp_q cells of DIV clocks.
  task automatic check_wave(input int u, input string name);
    int nbad;
    bit ok;
    nbad = 0;
    wait_start(u, ok);
    if (!ok) begin
      chk({name, "_start_timeout"}, 0, 1);
      return;
    end
    foreach (exp_q[i]) begin
      for (int k = 0; k < div_of(u); k++) begin
        if (txo[u] !== exp_q[i] || tx_busy[u] !== 1'b1) nbad++;
        @(negedge clk);
      end
    end
    if (txo[u] !== 1'b1 || tx_busy[u] !== 1'b0) nbad++;
    chk(name, nbad, 0);
  endtask

  task automatic send_bytes(input int u, input logic [7:0] q[$],
                            input int max_gap);
    foreach (q[i]) begin
      int gap, t;
      logic r0;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) begin
        r0 = tx_rdy[u];
        tx_vld[u] = 1'b0;
        tx_byte[u] = 8'($urandom);
        #1;
        if (tx_rdy[u] !== r0) rdy_viol++;
        repeat (gap) @(negedge clk);
      end
      r0 = tx_rdy[u];
      tx_byte[u] = q[i];
      tx_vld[u] = 1'b1;
      #1;
      if (tx_rdy[u] !== r0) rdy_viol++;
      t = 0;
      while (tx_rdy[u] !== 1'b1 && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 4000) begin
        chk("handshake_timeout", 0, 1);
        tx_vld[u] = 1'b0;
        return;
      end
      @(negedge clk);
      acc_q.push_back(cyc);
      sent_q.push_back(q[i]);
    end
    tx_vld[u] = 1'b0;
  endtask

  // Serial decoder on the DIV=3 instance: samples each cell at its middle.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txo[2] === 1'b0) begin
        @(negedge clk);
        if (txo[2] !== 1'b0) fr_err++;
        for (int k = 0; k < 8; k++) begin
          repeat (3) @(negedge clk);
          rb[k] = txo[2];
        end
        repeat (3) @(negedge clk);
        if (txo[2] !== 1'b1) fr_err++;
        rx_q.push_back(rb);
      end
    end
  end

  task automatic drain_and_score(input string name);
    int n;
    tmo = 0;
    while (rx_q.size() < sent_q.size() && tmo < 500) begin
      @(negedge clk);
      tmo++;
    end
    repeat (40) @(negedge clk);
    chk({name, "_count"}, rx_q.size(), sent_q.size());
    n = (rx_q.size() < sent_q.size()) ? rx_q.size() : sent_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (rx_q[i] !== sent_q[i]) bad++;
    chk({name, "_data"}, bad, 0);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      tx_vld[u] = 1'b0;
      tx_byte[u] = 8'h00;
    end
    tbl[0] = '{data: 8'hA5, frame: 10'b1101001010};
    tbl[1] = '{data: 8'h00, frame: 10'b1000000000};
    tbl[2] = '{data: 8'hFF, frame: 10'b1111111110};
    tbl[3] = '{data: 8'h3C, frame: 10'b1001111000};
    tbl[4] = '{data: 8'h81, frame: 10'b1100000010};

    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("reset_txo", txo[u], 1);
      chk("reset_rdy", tx_rdy[u], 1);
      chk("reset_busy", tx_busy[u], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames from idle, exact waveform and handshake timing
    foreach (tbl[i]) begin
      chk("t1_rdy_idle", tx_rdy[0], 1);
      tx_byte[0] = tbl[i].data;
      tx_vld[0] = 1'b1;
      @(negedge clk);
      tx_vld[0] = 1'b0;
      tx_byte[0] = ~tbl[i].data;
      chk("t1_rdy_held", tx_rdy[0], 0);
      chk("t1_txo_pre", txo[0], 1);
      chk("t1_busy_pre", tx_busy[0], 0);
      @(negedge clk);
      chk("t1_txo_fall", txo[0], 0);
      chk("t1_rdy_back", tx_rdy[0], 1);
      exp_q.delete();
      for (int k = 0; k < 10; k++) exp_q.push_back(tbl[i].frame[k]);
      check_wave(0, "t1_frame");
      repeat (2) @(negedge clk);
    end

    // Back-to-back with tx_vld held: third byte stalls until second loads
    acc_q.delete();
    exp_q.delete();
    add_frame(8'h00, 1);
    add_frame(8'hFF, 1);
    add_frame(8'h5A, 1);
    bq = {8'h00, 8'hFF, 8'h5A};
    fork
      send_bytes(0, bq, 0);
      check_wave(0, "t2_b2b_wave");
    join
    chk("t2_acc_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t2_second_accept", acc_q[1] - acc_q[0], 2);
      chk("t2_third_stall", acc_q[2] - acc_q[0], 502);
    end
    repeat (2) @(negedge clk);

    // Two stop bits: 550-clock frames chained with no gap
    acc_q.delete();
    exp_q.delete();
    add_frame(8'h3C, 2);
    add_frame(8'h96, 2);
    bq = {8'h3C, 8'h96};
    fork
      send_bytes(1, bq, 0);
      check_wave(1, "t3_stop2_wave");
    join
    chk("t3_acc_count", acc_q.size(), 2);
    repeat (2) @(negedge clk);

    // Reset mid-frame with a byte held
    bq = {8'hA5, 8'h3C};
    fork
      send_bytes(0, bq, 0);
      begin
        wait_start(0, ok_g);
        repeat (237) @(negedge clk);
      end
    join
    chk("t4_started", ok_g, 1);
    chk("t4_busy_pre", tx_busy[0], 1);
    chk("t4_held_pre", tx_rdy[0], 0);
    chk("t4_txo_low_pre", txo[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_txo_async", txo[0], 1);
    chk("t4_rdy_async", tx_rdy[0], 1);
    chk("t4_busy_async", tx_busy[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (txo[0] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_rdy[0] !== 1'b1)
        bad++;
    end
    chk("t4_quiet_after_reset", bad, 0);
    exp_q.delete();
    add_frame(8'h6E, 1);
    bq = {8'h6E};
    fork
      send_bytes(0, bq, 0);
      check_wave(0, "t4_recover_wave");
    join

    // Decoded stream: full byte sweep back-to-back
    sent_q.delete();
    rx_q.delete();
    bq.delete();
    for (int i = 0; i < 256; i++) bq.push_back(8'(i));
    send_bytes(2, bq, 0);
    drain_and_score("t5_sweep");

    // Random bytes with random tx_vld gaps
    sent_q.delete();
    rx_q.delete();
    bq.delete();
    repeat (1000) bq.push_back(8'($urandom));
    send_bytes(2, bq, 3);
    drain_and_score("t6_random");
    chk("t6_framing", fr_err, 0);
    chk("t6_rdy_vld_path", rdy_viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
